// File: rtl/color_pkg.sv
// color_pkg
//   Shared definitions for the colour run-length tracking path.
//   - Color_state      : one-bit colour as stored in records (Blue = 0, Red = 1)
//   - tracker_state_e  : run tracker FSM states
//   - CODE_BLUE/RED    : legal 2-bit codes from the upstream colour FSM
//   - code_is_legal    : true for the two legal codes
//   - code_to_color    : maps a legal code to its record colour
//   Record layout {color, len} is a packed struct declared in the tracker,
//   where COUNT_WIDTH is known.
package color_pkg;

  typedef enum logic {
    BLUE = 1'b0,
    RED  = 1'b1
  } Color_state;

  typedef enum logic {
    T_IDLE = 1'b0,
    T_RUN  = 1'b1
  } tracker_state_e;

  localparam logic [1:0] CODE_BLUE = 2'h1;
  localparam logic [1:0] CODE_RED  = 2'h2;

  function automatic logic code_is_legal(input logic [1:0] c);
    return (c == CODE_BLUE) || (c == CODE_RED);
  endfunction

  function automatic Color_state code_to_color(input logic [1:0] c);
    return (c == CODE_RED) ? RED : BLUE;
  endfunction

endpackage

// File: rtl/color_rec_fifo.sv
// color_rec_fifo
//   DEPTH-entry synchronous FIFO for run records.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     push        : write push_data at the tail (honoured when not full, or
//                   when full and a pop happens in the same cycle)
//     push_data   : record to write
//     pop         : remove the head record (ignored when empty)
//     head        : head record, read directly from storage
//     full, empty : occupancy flags
//     dropped     : push refused this cycle because the FIFO was full
//   Pointers carry one extra wrap bit so full and empty are distinguished by
//   comparing the MSBs of otherwise equal pointers.
module color_rec_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic             dropped
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_pop  = pop && !empty;
  // When full, a same-cycle pop frees the head slot, which is exactly the
  // slot the tail points at, so the write lands in the freed entry.
  assign do_push = push && (!full || do_pop);
  assign dropped = push && !do_push;

  assign head = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      // Storage is cleared so the head fields read zero out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/color_run_tracker.sv
// color_run_tracker
//   Compresses the per-cycle colour code stream into run-length records and
//   buffers them in a FIFO.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     code_valid  : code is valid this cycle
//     code        : 2'h1 Blue, 2'h2 Red, others illegal
//     flush       : close the open run (only when code_valid = 0)
//     rec_valid   : FIFO head holds a record
//     rec_ready   : consumer takes the head record
//     rec_color   : head record colour (Blue 0, Red 1)
//     rec_len     : head record run length
//     overflow    : sticky, a record was dropped on a full FIFO
//     illegal     : sticky, an illegal code was seen
//   Handshake: a record transfers on every rising edge where rec_valid and
//   rec_ready are both 1; rec_color/rec_len hold steady while rec_valid = 1
//   and rec_ready = 0, and rec_valid never depends on rec_ready.
//   The FSM state is held in `state` (tracker_state_e) for observation.
module color_run_tracker
  import color_pkg::*;
#(
  parameter int COUNT_WIDTH = 8,
  parameter int DEPTH       = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   code_valid,
  input  logic [1:0]             code,
  input  logic                   flush,
  output logic                   rec_valid,
  input  logic                   rec_ready,
  output logic                   rec_color,
  output logic [COUNT_WIDTH-1:0] rec_len,
  output logic                   overflow,
  output logic                   illegal
);

  typedef struct packed {
    Color_state             color;
    logic [COUNT_WIDTH-1:0] len;
  } rec_t;

  localparam logic [COUNT_WIDTH-1:0] LEN_MAX = '1;
  localparam logic [COUNT_WIDTH-1:0] LEN_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  tracker_state_e         state;
  Color_state             cur_color;
  logic [COUNT_WIDTH-1:0] cur_len;

  logic       legal;
  logic       code_ok;
  Color_state new_color;
  logic       do_flush;
  logic       do_change;
  logic       push;
  logic       pop;
  rec_t       push_rec;
  rec_t       head_rec;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_dropped;

  assign legal     = code_is_legal(code);
  assign new_color = code_to_color(code);
  assign code_ok   = code_valid && legal;

  // A valid code always wins over flush, so flush only closes a run on an
  // idle code cycle.
  assign do_flush  = !code_valid && flush && (state == T_RUN);
  assign do_change = code_ok && (state == T_RUN) && (new_color != cur_color);
  assign push      = do_flush || do_change;
  assign push_rec  = '{color: cur_color, len: cur_len};

  assign rec_valid = !fifo_empty;
  assign pop       = rec_valid && rec_ready;
  assign rec_color = head_rec.color;
  assign rec_len   = head_rec.len;

  color_rec_fifo #(
    .WIDTH ($bits(rec_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_rec),
    .pop       (pop),
    .head      (head_rec),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .dropped   (fifo_dropped)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= T_IDLE;
      cur_color <= BLUE;
      cur_len   <= '0;
      overflow  <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      if (code_valid && !legal) begin
        illegal <= 1'b1;
      end
      // The run still restarts/closes even when its record is dropped.
      if (fifo_dropped) begin
        overflow <= 1'b1;
      end
      case (state)
        T_IDLE: begin
          if (code_ok) begin
            state     <= T_RUN;
            cur_color <= new_color;
            cur_len   <= LEN_ONE;
          end
        end
        T_RUN: begin
          if (code_ok) begin
            if (new_color != cur_color) begin
              cur_color <= new_color;
              cur_len   <= LEN_ONE;
            end else if (cur_len != LEN_MAX) begin
              cur_len <= cur_len + LEN_ONE;
            end
          end else if (do_flush) begin
            state   <= T_IDLE;
            cur_len <= '0;
          end
        end
        default: state <= T_IDLE;
      endcase
    end
  end

  // fifo_full is folded into fifo_dropped; kept for observation.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_color_run_tracker.sv
module tb_color_run_tracker;

  localparam int CW      = 2;
  localparam int D       = 4;
  localparam int RW      = CW + 1;
  localparam int LEN_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          code_valid = 1'b0;
  logic [1:0]    code = 2'h0;
  logic          flush = 1'b0;
  logic          rec_valid;
  logic          rec_ready = 1'b0;
  logic          rec_color;
  logic [CW-1:0] rec_len;
  logic          overflow;
  logic          illegal;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the run as plain integers, the FIFO as a queue.
  logic [RW-1:0] exp_q[$];
  bit            m_open;
  int            m_color;
  int            m_len;
  bit            m_ovf;
  bit            m_ill;

  color_run_tracker #(
    .COUNT_WIDTH (CW),
    .DEPTH       (D)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .code_valid (code_valid),
    .code       (code),
    .flush      (flush),
    .rec_valid  (rec_valid),
    .rec_ready  (rec_ready),
    .rec_color  (rec_color),
    .rec_len    (rec_len),
    .overflow   (overflow),
    .illegal    (illegal)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // ---------------- model ----------------
  task automatic model_reset();
    exp_q.delete();
    m_open  = 0;
    m_color = 0;
    m_len   = 0;
    m_ovf   = 0;
    m_ill   = 0;
  endtask

  task automatic emit(input int color, input int len);
    logic [RW-1:0] r;
    r = {color[0], len[CW-1:0]};
    // Monitor already popped this cycle's transfer, so a full queue here
    // means no slot was freed.
    if (exp_q.size() == D) m_ovf = 1;
    else exp_q.push_back(r);
  endtask

  task automatic model_step(input bit cv, input logic [1:0] cd, input bit fl);
    int c;
    if (cv) begin
      if (cd == 2'h1 || cd == 2'h2) begin
        c = (cd == 2'h2) ? 1 : 0;
        if (!m_open) begin
          m_open = 1; m_color = c; m_len = 1;
        end else if (c == m_color) begin
          m_len = (m_len < LEN_MAX) ? m_len + 1 : LEN_MAX;
        end else begin
          emit(m_color, m_len);
          m_color = c; m_len = 1;
        end
      end else begin
        m_ill = 1;
      end
    end else if (fl && m_open) begin
      emit(m_color, m_len);
      m_open = 0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input bit cv, input logic [1:0] cd, input bit fl, input bit rdy);
    code_valid = cv;
    code       = cd;
    flush      = fl;
    rec_ready  = rdy;
    @(posedge clk);
    model_step(cv, cd, fl);
    #1;
  endtask

  task automatic send(input logic [1:0] cd, input bit rdy);
    step(1'b1, cd, 1'b0, rdy);
  endtask

  task automatic do_flush(input bit rdy);
    step(1'b0, 2'h0, 1'b1, rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 2'h0, 1'b0, rdy);
  endtask

  // Asynchronous reset applied between clock edges; outputs checked at once.
  task automatic reset_now(input string tag);
    code_valid = 1'b0; flush = 1'b0; rec_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk({tag, "_rec_valid"}, rec_valid, 0);
    chk({tag, "_rec_color"}, rec_color, 0);
    chk({tag, "_rec_len"},   rec_len, 0);
    chk({tag, "_overflow"},  overflow, 0);
    chk({tag, "_illegal"},   illegal, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [RW-1:0] exp_rec;
    if (rst_n) begin
      chk("rec_valid", rec_valid, (exp_q.size() != 0) ? 1 : 0);
      chk("overflow", overflow, m_ovf);
      chk("illegal", illegal, m_ill);
      if (rec_valid && rec_ready && exp_q.size() != 0) begin
        exp_rec = exp_q.pop_front();
        chk("rec_head", {rec_color, rec_len}, exp_rec);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    #1;
    reset_now("reset");

    // Basic runs: B,B,B,R,R, flush with ready held high.
    send(2'h1, 1); send(2'h1, 1); send(2'h1, 1);
    send(2'h2, 1); send(2'h2, 1);
    do_flush(1);
    idle(3, 1);

    // Saturation: six Blues then flush gives one record of LEN_MAX.
    for (int i = 0; i < 6; i++) send(2'h1, 1);
    do_flush(1);
    idle(3, 1);

    // Overflow: 7 alternating codes then flush with ready low.
    for (int i = 0; i < 7; i++) send((i % 2 == 0) ? 2'h1 : 2'h2, 0);
    do_flush(0);
    idle(2, 0);
    idle(6, 1);

    // Full FIFO with a concurrent pop on a colour change.
    reset_now("reset2");
    send(2'h1, 0); send(2'h2, 0); send(2'h1, 0); send(2'h2, 0); send(2'h1, 0);
    idle(1, 0);
    send(2'h2, 1);
    idle(1, 0);
    do_flush(1);
    idle(7, 1);

    // Illegal code mid-run, flush with code_valid, flush in idle.
    reset_now("reset3");
    send(2'h2, 1); send(2'h2, 1);
    send(2'h3, 1);
    send(2'h0, 1);
    step(1'b1, 2'h2, 1'b1, 1);
    do_flush(1);
    idle(2, 1);
    do_flush(1);
    do_flush(1);
    idle(2, 1);

    // Async reset mid-run with two records buffered, then B,flush.
    reset_now("reset4");
    send(2'h1, 0); send(2'h2, 0); send(2'h1, 0);
    idle(1, 0);
    reset_now("reset5");
    send(2'h1, 1);
    do_flush(1);
    idle(3, 1);

    // Randomised traffic.
    reset_now("reset6");
    for (int i = 0; i < 600; i++) begin
      logic [1:0] cd;
      int sel;
      sel = $urandom_range(0, 19);
      if (sel == 0) cd = 2'h0;
      else if (sel == 1) cd = 2'h3;
      else cd = ($urandom_range(0, 2) == 0) ? 2'h2 : 2'h1;
      step(($urandom_range(0, 9) < 7), cd, ($urandom_range(0, 9) < 3),
           ($urandom_range(0, 9) < 6));
    end
    do_flush(1);
    idle(D + 4, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
